// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared widths, stage indices and scoreboard entry layout for the AT hazard logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

  // Default Tuse/Tnew width and mult/div busy lengths
  localparam int TW_DEF         = 2;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  // Register address width
  localparam int AW = 5;

  // Stage indices: ID is the consumer-only stage, E/M/W hold results
  localparam int STG_ID = 0;
  localparam int STG_E  = 1;
  localparam int STG_M  = 2;
  localparam int STG_W  = 3;

  // Forwarding select value meaning "take the GRF / pipeline value"
  localparam int FWD_NONE = 0;

  // Per-stage scoreboard entry; Tnew lives beside it because its width is a module parameter
  typedef struct packed {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic          md_start;
    logic          md_is_div;
  } sb_entry_t;

endpackage

// File: rtl/at_match.sv
// at_match: finds the youngest producer of addr in stages START+1..NSTAGE of the scoreboard.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module at_match
  import cpu_defs::*;
#(
  parameter int NSTAGE = 3,
  parameter int TW     = TW_DEF,
  parameter int START  = 0,
  localparam int SELW  = $clog2(NSTAGE + 1)
) (
  input  logic [AW-1:0]        addr,
  input  logic [NSTAGE*AW-1:0] wa_all,
  input  logic [NSTAGE*TW-1:0] tnew_all,
  output logic                 hit,
  output logic [SELW-1:0]      k,
  output logic [TW-1:0]        tnew_k
);

  // Scan oldest to youngest so the nearest (youngest) producer wins; $0 never matches
  always_comb begin
    hit    = 1'b0;
    k      = SELW'(FWD_NONE);
    tnew_k = '0;
    for (int j = NSTAGE; j > START; j--) begin
      if (addr != '0 && wa_all[(j-1)*AW +: AW] == addr) begin
        hit    = 1'b1;
        k      = SELW'(j);
        tnew_k = tnew_all[(j-1)*TW +: TW];
      end
    end
  end

endmodule

// File: rtl/at_hazard_unit.sv
// at_hazard_unit: AT scoreboard for the MIPS pipeline; produces ID stall, forwarding selects, mult/div interlock.
// Latency: outputs combinational from registered scoreboard plus ID fields; scoreboard shifts every clk.
// Backpressure: stall freezes PC/ID and loads a bubble into stage 1; stages 2..NSTAGE always advance.
module at_hazard_unit
  import cpu_defs::*;
#(
  parameter int NSTAGE     = 3,
  parameter int TW         = TW_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  localparam int SELW      = $clog2(NSTAGE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          id_ra1,
  input  logic [AW-1:0]          id_ra2,
  input  logic [TW-1:0]          id_tuse1,
  input  logic [TW-1:0]          id_tuse2,
  input  logic [AW-1:0]          id_wa,
  input  logic [TW-1:0]          id_tnew,
  input  logic                   id_md_start,
  input  logic                   id_md_is_div,
  input  logic                   id_md_use,
  output logic                   stall,
  output logic                   md_busy,
  output logic [NSTAGE*SELW-1:0] fwd_sel1,
  output logic [NSTAGE*SELW-1:0] fwd_sel2
);

  localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  sb_entry_t             sb_q   [1:NSTAGE];
  logic [TW-1:0]         tnew_q [1:NSTAGE];
  logic [CW-1:0]         cnt_q;
  logic [NSTAGE*AW-1:0]  wa_all;
  logic [NSTAGE*TW-1:0]  tnew_all;

  logic                  hit1 [NSTAGE];
  logic                  hit2 [NSTAGE];
  logic [SELW-1:0]       k1   [NSTAGE];
  logic [SELW-1:0]       k2   [NSTAGE];
  logic [TW-1:0]         tn1  [NSTAGE];
  logic [TW-1:0]         tn2  [NSTAGE];
  logic [AW-1:0]         rd1  [NSTAGE];
  logic [AW-1:0]         rd2  [NSTAGE];

  logic                  data_stall;
  logic                  md_stall;
  logic                  busy_raw;
  logic                  stall_raw;

  // Flatten producer addresses and remaining Tnew for the lookup instances
  always_comb begin
    wa_all   = '0;
    tnew_all = '0;
    for (int k = 1; k <= NSTAGE; k++) begin
      wa_all[(k-1)*AW +: AW]   = sb_q[k].wa;
      tnew_all[(k-1)*TW +: TW] = tnew_q[k];
    end
  end

  // One lookup per read port per consumer stage; ID consumes the live decoder fields
  for (genvar s = 0; s < NSTAGE; s++) begin : g_cons
    if (s == STG_ID) begin : g_id
      assign rd1[s] = id_ra1;
      assign rd2[s] = id_ra2;
    end else begin : g_pipe
      assign rd1[s] = sb_q[s].ra1;
      assign rd2[s] = sb_q[s].ra2;
    end

    at_match #(.NSTAGE(NSTAGE), .TW(TW), .START(s)) u_match1 (
      .addr     (rd1[s]),
      .wa_all   (wa_all),
      .tnew_all (tnew_all),
      .hit      (hit1[s]),
      .k        (k1[s]),
      .tnew_k   (tn1[s])
    );

    at_match #(.NSTAGE(NSTAGE), .TW(TW), .START(s)) u_match2 (
      .addr     (rd2[s]),
      .wa_all   (wa_all),
      .tnew_all (tnew_all),
      .hit      (hit2[s]),
      .k        (k2[s]),
      .tnew_k   (tn2[s])
    );
  end

  // Stall when the nearest producer is later than the ID consumer needs it, or HI/LO is in use
  always_comb begin
    data_stall = (hit1[STG_ID] && (tn1[STG_ID] > id_tuse1)) ||
                 (hit2[STG_ID] && (tn2[STG_ID] > id_tuse2));
    busy_raw   = sb_q[1].md_start || (cnt_q != '0);
    md_stall   = id_md_use && busy_raw;
    stall_raw  = data_stall || md_stall;
  end

  // Drive outputs, held quiet while reset is asserted; only ready producers are forwarded
  always_comb begin
    stall    = !reset && stall_raw;
    md_busy  = !reset && busy_raw;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int s = 0; s < NSTAGE; s++) begin
      if (!reset && hit1[s] && tn1[s] == '0) fwd_sel1[s*SELW +: SELW] = k1[s];
      if (!reset && hit2[s] && tn2[s] == '0) fwd_sel2[s*SELW +: SELW] = k2[s];
    end
  end

  // Scoreboard shift: stage 1 takes ID or a bubble, older stages age with saturating Tnew
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        sb_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      if (stall_raw) begin
        sb_q[1]   <= '0;
        tnew_q[1] <= '0;
      end else begin
        sb_q[1]   <= '{ra1: id_ra1, ra2: id_ra2, wa: id_wa,
                       md_start: id_md_start, md_is_div: id_md_is_div};
        tnew_q[1] <= id_tnew;
      end
      for (int k = 2; k <= NSTAGE; k++) begin
        sb_q[k]   <= sb_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
    end
  end

  // Mult/div busy counter: loaded when the op sits in E, then counts down to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (sb_q[1].md_start) begin
      cnt_q <= sb_q[1].md_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_at_hazard_unit.sv
// tb_at_hazard_unit: directed scenarios plus random traffic checked against a timeline model.
// Latency: model tracks each instruction by the cycle it entered E.
// Backpressure: model decides bubbles from its own stall prediction.
module tb_at_hazard_unit;
  import cpu_defs::*;

  localparam int NSTAGE = 3;
  localparam int TW     = 2;
  localparam int MULC   = 5;
  localparam int DIVC   = 10;
  localparam int SELW   = $clog2(NSTAGE + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [4:0]             id_ra1, id_ra2, id_wa;
  logic [TW-1:0]          id_tuse1, id_tuse2, id_tnew;
  logic                   id_md_start, id_md_is_div, id_md_use;
  logic                   stall, md_busy;
  logic [NSTAGE*SELW-1:0] fwd_sel1, fwd_sel2;

  int n_checks = 0;
  int n_fail   = 0;

  at_hazard_unit #(.NSTAGE(NSTAGE), .TW(TW), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_ra1       (id_ra1),
    .id_ra2       (id_ra2),
    .id_tuse1     (id_tuse1),
    .id_tuse2     (id_tuse2),
    .id_wa        (id_wa),
    .id_tnew      (id_tnew),
    .id_md_start  (id_md_start),
    .id_md_is_div (id_md_is_div),
    .id_md_use    (id_md_use),
    .stall        (stall),
    .md_busy      (md_busy),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: instructions stamped with their E-entry cycle
  typedef struct {
    int wa;
    int ra1;
    int ra2;
    int tnew;
    int entry;
  } ins_t;

  ins_t pipe[$];
  int   t        = 0;
  bit   md_valid = 0;
  int   md_e     = 0;
  int   md_d     = 0;

  function automatic int stage_of(ins_t i);
    return t - i.entry + 1;
  endfunction

  function automatic int rem_of(ins_t i);
    int r = i.tnew - (t - i.entry);
    return (r < 0) ? 0 : r;
  endfunction

  // youngest instruction with destination r sitting strictly after stage s
  function automatic int find_prod(int r, int s);
    int best = -1;
    int bs   = 1000;
    if (r == 0) return -1;
    foreach (pipe[i]) begin
      int st = stage_of(pipe[i]);
      if (st > s && st <= NSTAGE && pipe[i].wa == r && st < bs) begin
        bs   = st;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic int find_stage(int s);
    foreach (pipe[i]) if (stage_of(pipe[i]) == s) return i;
    return -1;
  endfunction

  function automatic bit md_busy_m();
    return md_valid && (t >= md_e) && (t <= md_e + md_d);
  endfunction

  function automatic bit stall_m();
    int i1, i2;
    bit s = 0;
    if (reset) return 0;
    i1 = find_prod(int'(id_ra1), 0);
    i2 = find_prod(int'(id_ra2), 0);
    if (i1 >= 0 && rem_of(pipe[i1]) > int'(id_tuse1)) s = 1;
    if (i2 >= 0 && rem_of(pipe[i2]) > int'(id_tuse2)) s = 1;
    if (id_md_use && md_busy_m()) s = 1;
    return s;
  endfunction

  function automatic int exp_sel(int s, int p);
    int r, idx;
    if (reset) return 0;
    if (s == 0) begin
      r = (p == 1) ? int'(id_ra1) : int'(id_ra2);
    end else begin
      idx = find_stage(s);
      if (idx < 0) return 0;
      r = (p == 1) ? pipe[idx].ra1 : pipe[idx].ra2;
    end
    idx = find_prod(r, s);
    if (idx < 0) return 0;
    return (rem_of(pipe[idx]) == 0) ? stage_of(pipe[idx]) : 0;
  endfunction

  function automatic logic [NSTAGE*SELW-1:0] sel_m(int p);
    logic [NSTAGE*SELW-1:0] v = '0;
    for (int s = 0; s < NSTAGE; s++) v[s*SELW +: SELW] = SELW'(exp_sel(s, p));
    return v;
  endfunction

  // ---------------- stimulus plumbing
  task automatic set_id(input int ra1, input int ra2, input int tu1, input int tu2,
                        input int wa, input int tn, input bit mds, input bit mdd, input bit mdu);
    id_ra1       = 5'(ra1);
    id_ra2       = 5'(ra2);
    id_tuse1     = TW'(tu1);
    id_tuse2     = TW'(tu2);
    id_wa        = 5'(wa);
    id_tnew      = TW'(tn);
    id_md_start  = mds;
    id_md_is_div = mdd;
    id_md_use    = mdu;
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // advance one clock, updating the model with the same decision the pipeline should make
  task automatic tick();
    bit   st = stall_m();
    ins_t ni;
    @(posedge clk);
    if (reset) begin
      pipe.delete();
      md_valid = 0;
    end else if (!st) begin
      ni = '{wa: int'(id_wa), ra1: int'(id_ra1), ra2: int'(id_ra2),
             tnew: int'(id_tnew), entry: t + 1};
      pipe.push_back(ni);
      if (id_md_start) begin
        md_valid = 1;
        md_e     = t + 1;
        md_d     = id_md_is_div ? DIVC : MULC;
      end
    end
    t++;
    while (pipe.size() > 0 && stage_of(pipe[0]) > NSTAGE) void'(pipe.pop_front());
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      tick();
    end
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    reset = 1'b1;
    set_id(8, 8, 0, 0, 8, 3, 1, 1, 1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", md_busy); end
    n_checks++; if (fwd_sel1 !== '0) begin n_fail++; $display("FAIL rst_sel1: got %h want 0", fwd_sel1); end
    n_checks++; if (fwd_sel2 !== '0) begin n_fail++; $display("FAIL rst_sel2: got %h want 0", fwd_sel2); end
    tick();
    tick();
    reset = 1'b0;
    nop();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall: got %b want 0", stall); end
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_load_use();
    set_id(0, 0, 0, 0, 8, 2, 0, 0, 0);              // lw $8
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
    tick();
    set_id(8, 8, 1, 1, 9, 1, 0, 0, 0);              // addu $9,$8,$8
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall2: got %b want 0", stall); end
    tick();
    nop();
    n_checks++; if (fwd_sel1[STG_E*SELW +: SELW] !== SELW'(3))
      begin n_fail++; $display("FAIL lu_sel1_E: got %0d want 3", fwd_sel1[STG_E*SELW +: SELW]); end
    n_checks++; if (fwd_sel2[STG_E*SELW +: SELW] !== SELW'(3))
      begin n_fail++; $display("FAIL lu_sel2_E: got %0d want 3", fwd_sel2[STG_E*SELW +: SELW]); end
    flush(4);
  endtask

  task automatic test_branch();
    set_id(0, 0, 0, 0, 8, 1, 0, 0, 0);              // addu $8
    tick();
    set_id(8, 0, 0, 0, 0, 0, 0, 0, 0);              // beq $8,$0
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL br_stall1: got %b want 1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall2: got %b want 0", stall); end
    n_checks++; if (fwd_sel1[STG_ID*SELW +: SELW] !== SELW'(2))
      begin n_fail++; $display("FAIL br_sel1_ID: got %0d want 2", fwd_sel1[STG_ID*SELW +: SELW]); end
    n_checks++; if (fwd_sel2 !== '0) begin n_fail++; $display("FAIL br_sel2: got %h want 0", fwd_sel2); end
    tick();
    flush(4);
  endtask

  task automatic test_zero_reg();
    set_id(0, 0, 0, 0, 0, 2, 0, 0, 0);              // load into $0
    tick();
    set_id(0, 0, 0, 0, 9, 1, 0, 0, 0);              // addu reading $0
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zr_stall: got %b want 0", stall); end
    n_checks++; if (fwd_sel1 !== '0) begin n_fail++; $display("FAIL zr_sel1: got %h want 0", fwd_sel1); end
    n_checks++; if (fwd_sel2 !== '0) begin n_fail++; $display("FAIL zr_sel2: got %h want 0", fwd_sel2); end
    tick();
    nop();
    n_checks++; if (fwd_sel1 !== '0 || fwd_sel2 !== '0)
      begin n_fail++; $display("FAIL zr_sel_E: got %h/%h want 0/0", fwd_sel1, fwd_sel2); end
    flush(4);
  endtask

  task automatic test_shadow();
    set_id(0, 0, 0, 0, 8, 1, 0, 0, 0);              // addu $8
    tick();
    set_id(0, 0, 0, 0, 8, 2, 0, 0, 0);              // lw $8
    tick();
    set_id(29, 8, 1, 2, 0, 0, 0, 0, 0);             // sw $8, 0($29)
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sh_stall: got %b want 0", stall); end
    tick();
    nop();
    n_checks++; if (fwd_sel2[STG_E*SELW +: SELW] !== SELW'(0))
      begin n_fail++; $display("FAIL sh_sel2_E: got %0d want 0", fwd_sel2[STG_E*SELW +: SELW]); end
    tick();
    n_checks++; if (fwd_sel2[STG_M*SELW +: SELW] !== SELW'(3))
      begin n_fail++; $display("FAIL sh_sel2_M: got %0d want 3", fwd_sel2[STG_M*SELW +: SELW]); end
    n_checks++; if (fwd_sel1[STG_M*SELW +: SELW] !== SELW'(0))
      begin n_fail++; $display("FAIL sh_sel1_M: got %0d want 0", fwd_sel1[STG_M*SELW +: SELW]); end
    flush(4);
  endtask

  task automatic md_case(input bit is_div, input int want);
    int n = 0;
    bit busy_ok = 1;
    set_id(4, 5, 1, 1, 0, 0, 1, is_div, 1);         // mult/div
    tick();
    set_id(0, 0, 0, 0, 2, 1, 0, 0, 1);              // mflo
    for (int i = 0; i < 40 && stall === 1'b1; i++) begin
      n++;
      if (md_busy !== 1'b1) busy_ok = 0;
      tick();
    end
    n_checks++; if (n != want) begin n_fail++; $display("FAIL md_len div=%0b: got %0d want %0d", is_div, n, want); end
    n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL md_busy_hold div=%0b: got dropout want steady 1", is_div); end
    tick();
    flush(4);
  endtask

  task automatic test_muldiv();
    md_case(1'b1, 1 + DIVC);
    md_case(1'b0, 1 + MULC);
  endtask

  task automatic test_reset_mid_div();
    set_id(4, 5, 1, 1, 0, 0, 1, 1, 1);              // div
    tick();
    flush(5);
    set_id(0, 0, 0, 0, 8, 2, 0, 0, 0);              // lw $8
    tick();
    nop();
    tick();                                          // lw in M, counter at 4
    n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rmd_busy_pre: got %b want 1", md_busy); end
    reset = 1'b1;
    set_id(8, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmd_stall_in_rst: got %b want 0", stall); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmd_stall: got %b want 0", stall); end
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rmd_busy: got %b want 0", md_busy); end
    n_checks++; if (fwd_sel1 !== '0 || fwd_sel2 !== '0)
      begin n_fail++; $display("FAIL rmd_sel: got %h/%h want 0/0", fwd_sel1, fwd_sel2); end
    flush(4);
  endtask

  task automatic test_random();
    bit mds;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      mds   = ($urandom_range(0, 15) == 0);
      set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), mds, 1'($urandom_range(0, 1)),
             mds | ($urandom_range(0, 7) == 0));
      n_checks++; if (stall !== stall_m())
        begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, stall_m()); end
      n_checks++; if (md_busy !== (!reset && md_busy_m()))
        begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, md_busy, !reset && md_busy_m()); end
      n_checks++; if (fwd_sel1 !== sel_m(1))
        begin n_fail++; $display("FAIL rnd_sel1 c%0d: got %h want %h", c, fwd_sel1, sel_m(1)); end
      n_checks++; if (fwd_sel2 !== sel_m(2))
        begin n_fail++; $display("FAIL rnd_sel2 c%0d: got %h want %h", c, fwd_sel2, sel_m(2)); end
      tick();
    end
    reset = 1'b0;
    flush(NSTAGE + DIVC + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_shadow();
    test_muldiv();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/at_hazard_unit.md
Name: at_hazard_unit

Overview:
Parametrised successor to the per-instruction AT decoder for the pipelined MIPS core. It consumes the ID-stage A/T fields (read addresses, Tuse, write address, Tnew) and keeps a scoreboard pipeline of those fields for every stage after ID, decrementing Tnew on each advance. From that state it generates the ID stall, per-stage forwarding selects, and mult/div busy interlocking with a cycle counter. It sits beside the datapath and drives the stage-register enables and bubble insertion, and the forwarding muxes.

Parameters:
NSTAGE, 3, number of stages after ID that hold results (1=E, 2=M, 3=W); valid range 2..7
TW, 2, width of the Tuse/Tnew fields
MUL_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu
SELW, $clog2(NSTAGE+1), width of one forwarding select (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_ra1  in  5  ID rs address (0 = no read)
id_ra2  in  5  ID rt address (0 = no read)
id_tuse1  in  TW  cycles from ID until rs is needed
id_tuse2  in  TW  cycles from ID until rt is needed
id_wa  in  5  ID destination (0 = no write)
id_tnew  in  TW  cycles after E entry until result is ready
id_md_start  in  1  ID holds mult/multu/div/divu
id_md_is_div  in  1  qualifies id_md_start: 1 = div type
id_md_use  in  1  ID holds any HI/LO instruction (mfhi/mflo/mthi/mtlo/mult/div)
stall  out  1  freeze PC/ID and inject a bubble into E
md_busy  out  1  mult/div unit busy (counter != 0 or md_start in E)
fwd_sel1  out  NSTAGE*SELW  rs forwarding select; slice s for the consumer in stage s (0=ID .. NSTAGE-1)
fwd_sel2  out  NSTAGE*SELW  rt forwarding select, same layout

Behaviour:
- State per stage k=1..NSTAGE: ra1, ra2, wa, tnew, md_start, md_is_div. Reset clears all fields to 0. Mult/div counter cnt is cleared to 0 on reset.
- Advance on every clk when stall=0:
  - Stage 1 loads the ID fields.
  - Stage k+1 loads stage k, with tnew = (tnew==0) ? 0 : tnew-1 (saturating).
- When stall=1:
  - Stage 1 loads a bubble (all fields 0).
  - Stages 2..NSTAGE advance normally.
- Producer match for an address r seen from stage s: the smallest k>s with wa_k==r and r!=0. Younger producers shadow older ones. Reads of $0 never match.
- Data stall: for each port p at ID, if a producer k exists and tnew_k > id_tuse_p, then stall=1.
- Mult/div stall: if id_md_use and (stage1.md_start or cnt!=0), then stall=1. The stall output is the OR of the data and mult/div stalls.
- Mult/div counter:
  - When stage1.md_start=1, cnt loads DIV_CYCLES if stage1.md_is_div, else MUL_CYCLES, at the next edge.
  - Otherwise cnt decrements while nonzero.
  - md_busy = stage1.md_start | (cnt!=0).
- Forwarding: slice s of fwd_sel_p is k if producer k (for stage s's own ra_p; ID uses id_ra_p) exists with tnew_k==0, else 0 (read GRF/pipeline value). A matched producer with tnew_k>0 yields 0; the stall rule guarantees that value is not consumed.
- W to ID: forwarding k=NSTAGE is legal. Same-cycle GRF write/read bypass is the GRF's responsibility; this block still forwards W.
- All outputs are combinational from the registered state plus the ID inputs.
- During reset=1, force stall=0, md_busy=0 and all selects to 0. After reset deasserts, state is empty.
- Reset mid-operation (including during a divide) clears cnt and the scoreboard at the next edge. No residual stall remains.

Decomposition:
- Shared package (cpu_defs): TW, MUL_CYCLES/DIV_CYCLES defaults, stage index constants (STG_ID=0, STG_E=1, STG_M=2, STG_W=3), the scoreboard entry struct/field widths, and the fwd-select encoding (0 = no forward).
- One sub-module, at_match: combinational producer lookup (address, start stage → hit, k, tnew_k), instantiated per port per consumer stage. The counter and pipe registers stay in the top.

Test Plan:
1. lw $8 (wa=8, tnew=2), next addu $9,$8,$8 (ra1=ra2=8, tuse=1) → stall=1 exactly 1 cycle. When addu is in E, fwd_sel1[s=1]=fwd_sel2[s=1]=3.
2. addu $8 (tnew=1), then beq $8,$0 (tuse1=0) → stall 1 cycle, then fwd_sel1[s=0]=2 with no stall.
3. ori $0 (wa=0), then addu reading $0 → stall=0, all selects 0.
4. addu $8, lw $8, sw $8 as rt (tuse2=2) → no stall (nearest producer lw, tnew 2 ≤ 2). When sw reaches M, fwd_sel2[s=2]=3, not from the older addu.
5. div issued, next mflo → stall held for exactly 1+DIV_CYCLES=11 cycles, md_busy high throughout. Repeat with mult → 6 cycles.
6. Assert reset during divide (cnt=4) with a load in M → next cycle stall=0, md_busy=0, all selects 0, and a following use of that register does not stall.
